// File: rtl/fp_div_pkg.sv
// Shared types and constants for the two-requester fp_divider front end.
package fp_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int          FP_W       = 32;
  localparam logic [30:0] FP_INF_MAG = 31'h7F800000;

  // True for a +0 or -0 single-precision value.
  function automatic logic is_zero(input logic [FP_W-1:0] b);
    return (b[FP_W-2:0] == '0);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the grant doubles as the requester's ready.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last1_q;
  logic last1_d;

  // last1_q=1 means requester 1 was granted last, so requester 0 wins a tie.
  always_comb begin
    gnt0    = en & req0 & (~req1 | last1_q);
    gnt1    = en & req1 & (~req0 | ~last1_q);
    last1_d = last1_q;
    if (gnt0 | gnt1) begin
      last1_d = gnt1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last1_q <= 1'b1;
    end else begin
      last1_q <= last1_d;
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// Arbitrates two divide requesters onto one fp_divider, sequencing its
// run/settle phases and resolving divide-by-zero locally.
module fp_div_arbiter
  import fp_div_pkg::*;
#(
  parameter int RUN_CYCLES    = 26,
  parameter int SETTLE_CYCLES = 24
) (
  input  logic        int_clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_dz,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_go,
  input  logic [31:0] div_result,
  output logic [1:0]  dbg_state
);

  localparam int MAX_CYC = (RUN_CYCLES > SETTLE_CYCLES) ? RUN_CYCLES : SETTLE_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Handshake: a request transfers on an edge where valid & ready are both
  // high; a response transfers on an edge where rspN_valid & rspN_ready are high.
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic [FP_W-1:0] div_a_q, div_a_d;
  logic [FP_W-1:0] div_b_q, div_b_d;
  logic [FP_W-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_dz_q, rsp_dz_d;

  logic            gnt0, gnt1, accept, rsp_hs;
  logic [FP_W-1:0] sel_a, sel_b;

  rr_arb2 u_arb (
    .clk   (int_clk),
    .rst_n (rst_n),
    .en    (rst_n && (state_q == ST_IDLE)),
    .req0  (req0_valid),
    .req1  (req1_valid),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    rsp_data_d = rsp_data_q;
    rsp_dz_d   = rsp_dz_q;
    accept     = gnt0 | gnt1;
    sel_a      = gnt1 ? req1_a : req0_a;
    sel_b      = gnt1 ? req1_b : req0_b;
    rsp_hs     = owner_q ? rsp1_ready : rsp0_ready;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = gnt1;
          div_a_d = sel_a;
          div_b_d = sel_b;
          if (is_zero(sel_b)) begin
            // Signed infinity without touching the divider.
            rsp_data_d = {sel_a[FP_W-1] ^ sel_b[FP_W-1], FP_INF_MAG};
            rsp_dz_d   = 1'b1;
            state_d    = ST_RESP;
          end else begin
            rsp_dz_d = 1'b0;
            cnt_d    = CW'(RUN_CYCLES - 1);
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          rsp_data_d = div_result;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge int_clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      rsp_data_q <= '0;
      rsp_dz_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_dz_q   <= rsp_dz_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid = (state_q == ST_RESP) && owner_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_dz     = rsp_dz_q;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign div_go     = (state_q == ST_RUN);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter with a stand-in divider that only yields
// the quotient after exactly 26 cycles of div_go.
module tb_fp_div_arbiter;

  localparam int W = 34;

  logic        int_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_dz;
  logic [31:0] div_a, div_b, div_result;
  logic        div_go;
  logic [1:0]  dbg_state;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_e;
  int          acc_w;

  fp_div_arbiter dut (
    .int_clk    (int_clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .rsp_dz     (rsp_dz),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_go     (div_go),
    .div_result (div_result),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 int_clk = ~int_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stand-in divider ----------------
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h41000000_40000000: return 32'h40800000;
      64'h415C0000_40B00000: return 32'h40200000;
      64'hC15C0000_C0B00000: return 32'h40200000;
      64'h42C80000_3F800000: return 32'h42C80000;
      default:               return 32'h7FC00000;
    endcase
  endfunction

  int   go_cnt = 0;
  logic go_prev = 1'b0;
  always @(posedge int_clk) begin
    go_prev <= div_go;
    if (div_go) go_cnt <= go_prev ? go_cnt + 1 : 1;
  end
  assign div_result = (!div_go && go_cnt == 26) ? ref_div(div_a, div_b) : 32'hDEADBEEF;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every response handshake pops the oldest expected {id, dz, data}.
  always @(negedge int_clk) begin
    if (rst_n && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_id", 32'(rsp1_valid), 32'(sb_e[33]));
        check("sb_data", rsp_data, sb_e[31:0]);
        check("sb_dz", 32'(rsp_dz), 32'(sb_e[32]));
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one request, waits for its response, completes the handshake if the
  // response port is ready. Call at a negedge or shortly after a posedge.
  task automatic transact(input bit idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_data, input logic exp_dz,
                          input int exp_edges, output int acc_wait);
    int   n = 0;
    int   go = 0;
    logic other_v = 1'b0;
    logic other_r = 1'b0;
    logic mine;
    if (!idx) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else      begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    #1;
    while (!(idx ? req1_ready : req0_ready) && n < 300) begin
      @(negedge int_clk);
      n++;
    end
    acc_wait = n;
    if (n >= 300) begin
      check("accept_timeout", 32'(n), 32'd0);
      if (!idx) req0_valid = 1'b0; else req1_valid = 1'b0;
      return;
    end
    check("grant_exclusive", 32'(idx ? req0_ready : req1_ready), 32'd0);
    exp_q.push_back({idx, exp_dz, exp_data});
    @(posedge int_clk);
    #1;
    if (!idx) begin req0_valid = 1'b0; req0_a = 32'hA5A55A5A; req0_b = 32'h3C3C3C3C; end
    else      begin req1_valid = 1'b0; req1_a = 32'hA5A55A5A; req1_b = 32'h3C3C3C3C; end
    @(negedge int_clk);
    check("div_a", div_a, a);
    check("div_b", div_b, b);
    n = 0;
    mine = idx ? rsp1_valid : rsp0_valid;
    while (!mine && n < 200) begin
      go += int'(div_go);
      other_v |= idx ? rsp0_valid : rsp1_valid;
      other_r |= idx ? req0_ready : req1_ready;
      @(posedge int_clk);
      n++;
      @(negedge int_clk);
      mine = idx ? rsp1_valid : rsp0_valid;
    end
    check("rsp_latency", 32'(n), 32'(exp_edges));
    check("go_cycles", 32'(go), exp_dz ? 32'd0 : 32'd26);
    check("other_rsp_valid", 32'(other_v), 32'd0);
    check("other_ready_busy", 32'(other_r), 32'd0);
    if (idx ? rsp1_ready : rsp0_ready) begin
      @(posedge int_clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state, with a request pending that must not be granted.
    req1_a = 32'hC15C0000; req1_b = 32'hC0B00000; req1_valid = 1'b1;
    repeat (2) @(posedge int_clk);
    @(negedge int_clk);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_div_go", 32'(div_go), 32'd0);
    check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_div_a", div_a, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge int_clk);
    #1 rst_n = 1'b1;

    // First tie goes to requester 0, then requester 1 is served.
    transact(1'b0, 32'h415C0000, 32'h40B00000, 32'h40200000, 1'b0, 50, acc_w);
    transact(1'b1, 32'hC15C0000, 32'hC0B00000, 32'h40200000, 1'b0, 50, acc_w);
    check("rr_req1_next", 32'(acc_w), 32'd0);

    // Second tie: requester 0 again (8/2), then requester 1 with a -0 divisor.
    req1_a = 32'h41000000; req1_b = 32'h80000000; req1_valid = 1'b1;
    transact(1'b0, 32'h41000000, 32'h40000000, 32'h40800000, 1'b0, 50, acc_w);
    transact(1'b1, 32'h41000000, 32'h80000000, 32'hFF800000, 1'b1, 0, acc_w);

    // Backpressure on response 0 while requester 1 waits.
    rsp0_ready = 1'b0;
    req1_a = 32'h3F800000; req1_b = 32'h00000000; req1_valid = 1'b1;
    transact(1'b0, 32'h41000000, 32'h40000000, 32'h40800000, 1'b0, 50, acc_w);
    for (int i = 0; i < 10; i++) begin
      @(posedge int_clk);
      @(negedge int_clk);
      check("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
      check("bp_rsp_data", rsp_data, 32'h40800000);
      check("bp_req1_ready", 32'(req1_ready), 32'd0);
    end
    check("bp_state", 32'(dbg_state), 32'd3);
    @(posedge int_clk);
    #1 rsp0_ready = 1'b1;
    @(negedge int_clk);
    check("bp_hs_cycle_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge int_clk);
    #1;
    transact(1'b1, 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 0, acc_w);
    check("bp_accept_next_cycle", 32'(acc_w), 32'd0);

    // Abort a run at counter 10 with a one-cycle reset.
    req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_valid = 1'b1;
    @(negedge int_clk);
    check("abort_req0_ready", 32'(req0_ready), 32'd1);
    @(posedge int_clk);
    #1 req0_valid = 1'b0;
    repeat (15) @(posedge int_clk);
    #1;
    rst_n = 1'b0;
    req0_a = 32'h42C80000; req0_b = 32'h3F800000; req0_valid = 1'b1;
    req1_a = 32'hC0400000; req1_b = 32'h80000000; req1_valid = 1'b1;
    @(negedge int_clk);
    check("abort_div_go_before", 32'(div_go), 32'd1);
    check("abort_ready_in_rst", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge int_clk);
    #1 rst_n = 1'b1;
    @(negedge int_clk);
    check("abort_div_go", 32'(div_go), 32'd0);
    check("abort_div_a", div_a, 32'd0);
    check("abort_div_b", div_b, 32'd0);
    check("abort_rsp_data", rsp_data, 32'd0);
    check("abort_rsp_dz", 32'(rsp_dz), 32'd0);
    check("abort_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_ptr_tie", 32'({req0_ready, req1_ready}), 32'b10);
    transact(1'b0, 32'h42C80000, 32'h3F800000, 32'h42C80000, 1'b0, 50, acc_w);
    transact(1'b1, 32'hC0400000, 32'h80000000, 32'h7F800000, 1'b1, 0, acc_w);

    repeat (3) @(posedge int_clk);
    @(negedge int_clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div_arbiter.md
# fp_div_arbiter

Two-requester front end for the shared single-precision `fp_divider`. It accepts divide requests through valid/ready handshakes and arbitrates between the two requesters round-robin. It sequences the divider's operand, launch and settle phases, then returns the IEEE-754 quotient to the requester that issued it. Divide-by-zero is resolved locally without occupying the divider. It sits between the integer-side pipeline ports and the one `fp_divider` instance.

## Interface
- `RUN_CYCLES`, default 26: cycles `div_go` is held high per operation (≥1).
- `SETTLE_CYCLES`, default 24: cycles `div_go` is held low before result capture (≥1).
- `int_clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req0_valid` / `req1_valid`  in  1: request present.
- `req0_ready` / `req1_ready`  out  1: request accepted this cycle when valid & ready.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  32: dividend and divisor, IEEE-754 single.
- `rsp0_valid` / `rsp1_valid`  out  1: result for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1: requester takes the result.
- `rsp_data`  out  32: quotient, shared by both response ports.
- `rsp_dz`  out  1: result came from the divide-by-zero path.
- `div_a`, `div_b`  out  32: operands to `fp_divider.A/B`, registered.
- `div_go`  out  1: drives `fp_divider.fp_clk`.
- `div_result`  in  32: `fp_divider.Out`.

## Operation
- States: IDLE, RUN, SETTLE, RESP. One operation outstanding at a time.
- IDLE: the winner is the only requester seeing ready=1. Winner = the valid requester. If both are valid, the winner is the one not granted last.
  - Priority pointer resets to "1 granted last", so requester 0 wins the first tie.
  - Pointer updates only on accept.
- On accept:
  - Latch the owner id, `div_a <= a`, `div_b <= b`.
  - If `b[30:0]==0` (±0 divisor): go to RESP with `rsp_data = {a[31]^b[31], 8'hFF, 23'h0}` and `rsp_dz=1`.
  - Otherwise: `rsp_dz=0`, load the counter with RUN_CYCLES-1 and go to RUN.
- RUN: `div_go=1` and the counter decrements. At 0, load SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE: `div_go=0` and the counter decrements. At 0, capture `rsp_data <= div_result` and go to RESP.
- RESP: `rspN_valid=1` for the owner only, and `rsp_data`/`rsp_dz` are stable.
  - While `rspN_ready=0`, stay in RESP; no new request is accepted.
  - On handshake, return to IDLE. Accept is possible again on the next cycle, not the same one.
- Counter width is `$clog2(max(RUN_CYCLES,SETTLE_CYCLES))`, minimum 1 bit. No wrap-around: the counter is reloaded before each phase.
- Sign/NaN/denormal handling of the non-zero path is the divider's responsibility; it is passed through unchanged.

## Timing
- Reset (rst_n=0 at an edge):
  - State is IDLE and the counter is 0.
  - `div_go=0`, `div_a=div_b=0`, `rsp_data=0`, `rsp_dz=0`, `rsp0/1_valid=0`, pointer = 1.
  - `req0/1_ready=0` while `rst_n=0`.
- Reset mid-operation aborts it: the result is discarded, and no response is ever issued for the aborted request.
- Normal latency: accept at edge T, then `div_go` is high for edges T+1 … T+RUN_CYCLES.
  - `rsp_valid` is high from the cycle after edge T+RUN_CYCLES+SETTLE_CYCLES (default 50 cycles).
- Divide-by-zero latency: `rsp_valid` is high the cycle after the accept edge.
- Operand changes on `req*_a/b` after accept have no effect.
- Throughput: one operation per RUN_CYCLES+SETTLE_CYCLES+2 cycles with `rsp_ready` held high.

## Structure
- `fp_div_pkg`:
  - State enum.
  - `FP_W=32`.
  - `FP_INF_MAG=31'h7F800000`.
  - Function `is_zero(b)`.
- Sub-module `rr_arb2`: combinational 2-way round-robin grant, with a registered last-grant pointer and pointer update on accept.
- Everything else (FSM, counter, operand and result registers) lives in `fp_div_arbiter`.

## Test plan
- Req0 `8.0/2.0` (`41000000`/`40000000`), rsp0_ready=1:
  - `div_go` high for exactly 26 cycles.
  - rsp0_valid 50 cycles after accept, `rsp_data=40800000`, `rsp_dz=0`, rsp1_valid never high.
- Both valid at once:
  - Req0 `415C0000/40B00000` returns `40200000` first.
  - Req1 `C15C0000/C0B00000` then returns `40200000`.
  - Next tie goes to req0 again only after req1 has been served.
- Req1 `41000000/80000000` (−0 divisor):
  - rsp1_valid the cycle after accept, `rsp_data=FF800000`, `rsp_dz=1`, `div_go` never asserted.
- Backpressure: hold rsp0_ready=0 for 10 cycles with req1_valid=1.
  - rsp0_valid and `rsp_data` stay stable and req1_ready stays 0.
  - Release: req1 is accepted the cycle after the handshake.
- Deassert rst_n for 1 cycle at RUN count 10:
  - `div_go=0` and all outputs at their reset values next cycle.
  - No rsp_valid for the aborted request.
  - A new `42C80000/3F800000` request returns `42C80000`.
